// File: rtl/cd_tx_ser_if.sv
// Byte handshake between the TX byte fetcher (master) and the serializer.
// The fetcher sees the running CRC so it can substitute the two CRC bytes.
interface cd_tx_ser_if;
   logic [7:0]  data;
   logic        has_data;
   logic        ack_data;
   logic        is_crc_byte;
   logic        is_last_byte;
   logic [15:0] crc_data;

   modport master (
      output data, has_data, is_crc_byte, is_last_byte,
      input  ack_data, crc_data
   );

   modport slave (
      input  data, has_data, is_crc_byte, is_last_byte,
      output ack_data, crc_data
   );
endinterface

// File: rtl/cd_tx_ser.sv
// Async-character TX serializer (start, 8 data LSB first, stop) with
// running CRC-16/MODBUS over payload bytes and driver-enable control.
module cd_tx_ser #(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] div,
   input  logic             abort,
   cd_tx_ser_if.slave       up,
   output logic             tx,
   output logic             tx_en,
   output logic             busy,
   output logic             tx_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_GAP
   } state_t;

   localparam logic [DIV_W-1:0] CNT_ONE = DIV_W'(1);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic             last_q, last_d;
   logic [15:0]      crc_q, crc_d;
   logic             tx_q, tx_d;
   logic             tx_en_q, tx_en_d;
   logic             busy_q, busy_d;
   logic             ack_q, ack_d;
   logic             done_q, done_d;
   logic             bit_end;

   function automatic logic [15:0] crc16(
      input logic [15:0] c,
      input logic [7:0]  d
   );
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      end
      return r;
   endfunction

   assign bit_end = (cnt_q == '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      div_d     = div_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      last_d    = last_q;
      crc_d     = crc_q;
      ack_d     = 1'b0;
      done_d    = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (up.has_data) begin
               div_d   = div;
               cnt_d   = div;
               crc_d   = 16'hFFFF;
               state_d = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               // data is sampled only here so it may change during start
               shift_d   = up.data;
               last_d    = up.is_last_byte;
               ack_d     = 1'b1;
               bit_idx_d = 3'd0;
               cnt_d     = div_q;
               state_d   = S_DATA;
               if (!up.is_crc_byte && !up.is_last_byte) begin
                  crc_d = crc16(crc_q, up.data);
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               cnt_d     = div_q;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               cnt_d = div_q;
               if (last_q) begin
                  done_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = S_IDLE;
               end else if (up.has_data) begin
                  state_d = S_START;
               end else begin
                  state_d = S_GAP;
               end
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end
         S_GAP: begin
            if (up.has_data) begin
               cnt_d   = div_q;
               state_d = S_START;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort) begin
         state_d   = S_IDLE;
         cnt_d     = '0;
         bit_idx_d = 3'd0;
         last_d    = 1'b0;
         crc_d     = 16'hFFFF;
         ack_d     = 1'b0;
         done_d    = 1'b0;
      end

      // line outputs are registered from the next state
      tx_d    = 1'b1;
      tx_en_d = 1'b1;
      busy_d  = 1'b1;
      unique case (state_d)
         S_IDLE: begin
            tx_en_d = 1'b0;
            busy_d  = 1'b0;
         end
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         div_q     <= '0;
         shift_q   <= 8'h00;
         bit_idx_q <= 3'd0;
         last_q    <= 1'b0;
         crc_q     <= 16'hFFFF;
         tx_q      <= 1'b1;
         tx_en_q   <= 1'b0;
         busy_q    <= 1'b0;
         ack_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         last_q    <= last_d;
         crc_q     <= crc_d;
         tx_q      <= tx_d;
         tx_en_q   <= tx_en_d;
         busy_q    <= busy_d;
         ack_q     <= ack_d;
         done_q    <= done_d;
      end
   end

   assign tx          = tx_q;
   assign tx_en       = tx_en_q;
   assign busy        = busy_q;
   assign tx_done     = done_q;
   assign up.ack_data = ack_q;
   assign up.crc_data = crc_q;

endmodule

// File: doc/cd_tx_ser.md
Name: cd_tx_ser

Overview:
- Bit-level transmit serializer, directly downstream of the TX byte fetcher.
- Consumes bytes over a has_data/ack_data handshake and shifts each out as an async character: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Computes the running CRC-16/MODBUS over payload bytes and feeds it back as crc_data, so the fetcher can substitute the two CRC bytes.
- Drives the line pin and the transceiver driver enable.

Parameters:
- DIV_W, 16, width of the bit-period divisor input.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- div  in  DIV_W  bit period minus one, in clk cycles; sampled at frame start
- abort  in  1  kill current frame immediately
- data  in  8  byte to send
- has_data  in  1  byte available
- ack_data  out  1  one-cycle pulse: data consumed
- is_crc_byte  in  1  current byte is CRC low byte
- is_last_byte  in  1  current byte is final byte of frame
- crc_data  out  16  running CRC-16/MODBUS
- tx  out  1  serial line output, idle high
- tx_en  out  1  transceiver driver enable
- busy  out  1  frame in progress
- tx_done  out  1  one-cycle pulse: last stop bit finished

Behaviour:
- Reset values: tx=1, tx_en=0, busy=0, ack_data=0, tx_done=0, crc_data=16'hFFFF, state=IDLE, counters=0.
- Bit timer: counts div down to 0. One bit lasts div+1 clocks; div=0 gives 1 clock per bit. The divisor is latched as div_r on the IDLE->START transition and is ignored mid-frame.
- IDLE: tx=1, tx_en=0, busy=0. On has_data: latch div, set crc_data=16'hFFFF, go to START.
- START: tx=0, tx_en=1, busy=1. On the last clock of the bit:
  - latch data into the shift register;
  - latch is_last_byte into last_r;
  - pulse ack_data for exactly that cycle;
  - go to DATA with bit_idx=0.
  - Data is not sampled before this point, so the upstream stage may rewrite data (CRC substitution) at any time during the start bit.
- CRC update: on the same ack cycle, if !is_crc_byte && !is_last_byte, crc_data <= crc16(crc_data, data). crc16 uses reflected polynomial 16'hA001 over 8 iterations, LSB first. crc_data therefore holds its value while the CRC bytes are sent.
- DATA: tx=shift[0]. At each bit end, shift right and increment bit_idx. After bit_idx=7 ends, go to STOP.
- STOP: tx=1 for one bit period. At its end:
  - if last_r: tx_done pulses 1 cycle, go to IDLE; tx_en falls in the same cycle as tx_done.
  - else if has_data: go to START with no gap, giving 10*(div+1) clocks per byte back-to-back.
  - else: go to GAP.
- GAP: tx=1, tx_en=1, busy=1. Wait; on has_data go to START at the next clock (bit timer restarts at div_r).
- abort (any state, highest priority after reset):
  - next cycle: state=IDLE, tx=1, tx_en=0, busy=0;
  - no tx_done, no ack_data;
  - crc_data reset to 16'hFFFF.
- abort and ack in the same cycle: abort wins and ack_data is suppressed.
- reset mid-frame: same result as abort, plus all reset values.
- has_data dropping during START does not cancel the character: the start bit completes, and data is sampled as is.

Test Plan:
- div=3, single frame "123456789" (ASCII 0x31..0x39) plus two CRC bytes from crc_data, last flagged -> crc_data=16'h4B37 after byte 9; line carries 0x37 then 0x4B; each bit exactly 4 clocks; 11 bytes in 440 clocks; tx_done once.
- div=0, byte 0xA5 as only/last byte -> tx sequence 0,1,0,1,0,0,1,0,1,1 with 1 clock per bit; ack_data at clock 1 after START entry; tx_en high for exactly 10 clocks.
- div=2, has_data withheld 7 clocks after first stop bit -> tx=1 and tx_en=1 throughout GAP; next start bit begins 1 clock after has_data rises; crc_data unchanged during GAP.
- Change data from 0x11 to 0x22 mid start bit (div=7, at clock 4) -> 0x22 transmitted and included in CRC; exactly one ack_data pulse.
- abort asserted during DATA bit 3 -> next cycle tx=1, tx_en=0, busy=0, crc_data=16'hFFFF, no tx_done; following frame transmits normally.
- reset asserted during STOP of the non-last byte -> all outputs at reset values next cycle; div change mid-frame (3->9) has no effect until the next frame.
